// File: rtl/rom_rd_sched.sv
// Read scheduler and power sequencer for the 2048x32 latch-based ROM macro.
// Round-robin arbitration onto one ROM read port, fixed 2-cycle read latency, idle power-down.
module rom_rd_sched #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int IDLE_TO = 16
) (
    input  logic                     ickr,
    input  logic                     irst,
    input  logic [NREQ-1:0]          ireq_vld,
    input  logic [NREQ*ADDR_W-1:0]   ireq_addr,
    output logic [NREQ-1:0]          oreq_rdy,
    output logic [NREQ-1:0]          orsp_vld,
    output logic [DATA_W-1:0]        orsp_data,
    output logic                     orom_ren,
    output logic [ADDR_W-1:0]        orom_addr,
    input  logic [DATA_W-1:0]        irom_dout,
    output logic                     orom_pwreninb,
    input  logic                     irom_pwrenoutb,
    output logic [1:0]               ostate
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (IDLE_TO > 0) ? $clog2(IDLE_TO + 1) : 1;
    localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_TO);
    localparam bit CAN_SLEEP = (IDLE_TO != 0);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_PWRUP = 2'd1,
        ST_ON    = 2'd2,
        ST_PWRDN = 2'd3
    } state_t;

    state_t              r_state, w_nxt;
    logic [PW-1:0]       r_ptr;
    logic [CW-1:0]       r_idle;
    logic [NREQ-1:0]     r_tag1, r_tag2, r_rsp_vld;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_ren, r_pwreninb;
    logic [ADDR_W-1:0]   r_addr;

    logic                w_found, w_accept, w_busy, w_timeout, w_pwreninb_nxt;
    logic [PW-1:0]       w_gidx;
    logic [NREQ-1:0]     w_grant;

    // Scan downward so the lowest rotation offset from the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (ireq_vld[PW'((int'(r_ptr) + k) % NREQ)]) begin
                w_found = 1'b1;
                w_gidx  = PW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_accept  = (r_state == ST_ON) && w_found;
    assign w_busy    = (|r_tag1) || (|r_tag2);
    assign w_timeout = CAN_SLEEP && (r_idle == IDLE_MAX) && !(|ireq_vld);

    // FSM: state register
    always_ff @(posedge ickr or posedge irst) begin
        if (irst) r_state <= ST_OFF;
        else      r_state <= w_nxt;
    end

    // FSM: next state
    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            ST_OFF:   if (|ireq_vld)       w_nxt = ST_PWRUP;
            ST_PWRUP: if (!irom_pwrenoutb) w_nxt = ST_ON;
            ST_ON:    if (w_timeout)       w_nxt = ST_PWRDN;
            ST_PWRDN: if (irom_pwrenoutb)  w_nxt = ST_OFF;
            default:                       w_nxt = ST_OFF;
        endcase
    end

    // FSM: outputs (power enable is registered from the next state)
    always_comb begin
        w_grant        = '0;
        w_pwreninb_nxt = !((w_nxt == ST_PWRUP) || (w_nxt == ST_ON));
        if (w_accept) w_grant = NREQ'(1) << w_gidx;
    end

    assign oreq_rdy = w_grant;

    always_ff @(posedge ickr or posedge irst) begin
        if (irst) begin
            r_pwreninb <= 1'b1;
            r_ptr      <= '0;
            r_idle     <= '0;
            r_ren      <= 1'b0;
            r_addr     <= '0;
            r_tag1     <= '0;
            r_tag2     <= '0;
            r_rsp_vld  <= '0;
            r_rsp_data <= '0;
        end else begin
            r_pwreninb <= w_pwreninb_nxt;
            r_ren      <= w_accept;
            r_tag1     <= w_grant;
            r_tag2     <= r_tag1;
            r_rsp_vld  <= r_tag2;
            if (|r_tag2) r_rsp_data <= irom_dout;
            if (w_accept) begin
                r_addr <= ireq_addr[int'(w_gidx)*ADDR_W +: ADDR_W];
                r_ptr  <= (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
            end
            // Idle time only accrues in ON with nothing accepted or in flight.
            if (r_state != ST_ON || w_accept || w_busy) r_idle <= '0;
            else if (r_idle != IDLE_MAX)                r_idle <= r_idle + 1'b1;
        end
    end

    assign orsp_vld      = r_rsp_vld;
    assign orsp_data     = r_rsp_data;
    assign orom_ren      = r_ren;
    assign orom_addr     = r_addr;
    assign orom_pwreninb = r_pwreninb;
    assign ostate        = r_state;

endmodule

// File: tb/tb_rom_rd_sched.sv
// Bench for rom_rd_sched: ROM model with power feed-through, transaction-level reference
// model compared every cycle, plus directed literal checks of the test-plan scenarios.
module tb_rom_rd_sched;

    localparam int NREQ = 4, AW = 11, DW = 32, ITO = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   vld = '0;
    logic [NREQ*AW-1:0] addr = '0;
    logic [NREQ-1:0]   rdy, rsp_vld;
    logic [DW-1:0]     rsp_data, rom_dout = '0;
    logic              rom_ren, rom_pwreninb, rom_pwrenoutb;
    logic [AW-1:0]     rom_addr;
    logic [1:0]        state;

    int checks = 0, errors = 0;

    rom_rd_sched #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .IDLE_TO(ITO)) dut (
        .ickr(clk), .irst(rst), .ireq_vld(vld), .ireq_addr(addr), .oreq_rdy(rdy),
        .orsp_vld(rsp_vld), .orsp_data(rsp_data), .orom_ren(rom_ren), .orom_addr(rom_addr),
        .irom_dout(rom_dout), .orom_pwreninb(rom_pwreninb), .irom_pwrenoutb(rom_pwrenoutb),
        .ostate(state)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] image(input logic [AW-1:0] a);
        return (32'(a) * 32'h0100_0193) ^ 32'hC0DE_0000;
    endfunction

    // ROM: latches enable/address on the edge after they are driven, power chain feeds through.
    always @(posedge clk) if (rom_ren) rom_dout <= image(rom_addr);
    assign rom_pwrenoutb = rom_pwreninb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight reads are a queue of (due cycle, requester, address).
    typedef struct { int due; int req; logic [AW-1:0] a; } rd_t;
    rd_t pend[$];
    int m_state = 0, m_ptr = 0, m_idle = 0, cyc = 0, g;
    logic m_pw = 1'b1, m_ren = 1'b0, busy;
    logic [AW-1:0] m_addr = '0;
    logic [NREQ-1:0] m_rvld = '0;
    logic [DW-1:0] m_rdata = '0;

    function automatic int pick(input int ptr, input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int i);
        logic [NREQ*AW-1:0] t;
        t = addr;
        return t[i*AW +: AW];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_pw = 1'b1; m_ptr = 0; m_idle = 0; m_ren = 1'b0;
            m_addr = '0; m_rvld = '0; m_rdata = '0; pend.delete(); cyc = 0;
        end else begin
            cyc++;
            busy = (pend.size() != 0);
            g = (m_state == 2) ? pick(m_ptr, vld) : -1;
            m_rvld = '0;
            if (busy && pend[0].due == cyc) begin
                m_rvld  = NREQ'(1) << pend[0].req;
                m_rdata = image(pend[0].a);
                void'(pend.pop_front());
            end
            m_ren = (g >= 0);
            if (g >= 0) begin
                m_addr = addr_of(g);
                pend.push_back('{cyc + 2, g, addr_of(g)});
                m_ptr = (g + 1) % NREQ;
            end
            case (m_state)
                0: if (vld != 0) begin m_state = 1; m_pw = 1'b0; end
                1: if (m_pw == 1'b0) m_state = 2;
                2: begin
                    if (g >= 0 || busy) m_idle = 0;
                    else if (m_idle == ITO && ITO != 0) begin
                        m_state = 3; m_pw = 1'b1; m_idle = 0;
                    end else if (m_idle < ITO) m_idle++;
                end
                default: if (m_pw == 1'b1) m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        int gg;
        gg = (m_state == 2) ? pick(m_ptr, vld) : -1;
        chk("state", 32'(state), 32'(m_state));
        chk("pwreninb", 32'(rom_pwreninb), 32'(m_pw));
        chk("rdy", 32'(rdy), (gg >= 0) ? (32'd1 << gg) : 32'd0);
        chk("rom_ren", 32'(rom_ren), 32'(m_ren));
        chk("rom_addr", 32'(rom_addr), 32'(m_addr));
        chk("rsp_vld", 32'(rsp_vld), 32'(m_rvld));
        chk("rsp_data", rsp_data, m_rdata);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        addr[i*AW +: AW] = a;
    endtask

    initial begin
        step(2);
        // Cold start, req1 addr 0x005 held from reset release.
        rst = 1'b0; vld = 4'b0010; set_addr(1, 11'h005);
        chk("lit_reset_state", 32'(state), 0);
        chk("lit_reset_pw", 32'(rom_pwreninb), 1);
        chk("lit_reset_rvld", 32'(rsp_vld), 0);
        step(1);
        chk("lit_pwrup", 32'(state), 1);
        chk("lit_pwrup_pw", 32'(rom_pwreninb), 0);
        step(1);
        chk("lit_on", 32'(state), 2);
        chk("lit_rdy1", 32'(rdy), 32'b0010);
        step(1);
        chk("lit_ren", 32'(rom_ren), 1);
        chk("lit_addr5", 32'(rom_addr), 32'h005);
        vld = '0;
        step(1);
        chk("lit_no_rsp_yet", 32'(rsp_vld), 0);
        step(1);
        chk("lit_rsp1", 32'(rsp_vld), 32'b0010);
        chk("lit_data5", rsp_data, image(11'h005));
        // Idle power-down with IDLE_TO=4.
        step(4);
        chk("lit_still_on", 32'(state), 2);
        chk("lit_still_pw", 32'(rom_pwreninb), 0);
        step(1);
        chk("lit_pwrdn", 32'(state), 3);
        chk("lit_pwrdn_pw", 32'(rom_pwreninb), 1);
        step(1);
        chk("lit_off", 32'(state), 0);
        // Re-power on req2.
        vld = 4'b0100; set_addr(2, 11'h07A);
        step(3);
        chk("lit_addr7a", 32'(rom_addr), 32'h07A);
        vld = '0;
        step(2);
        chk("lit_rsp2", 32'(rsp_vld), 32'b0100);
        chk("lit_data7a", rsp_data, image(11'h07A));
        // Round robin, all four held, pointer currently 3.
        for (int i = 0; i < NREQ; i++) set_addr(i, AW'(i));
        vld = 4'b1111;
        step(1);
        chk("lit_rr_first", 32'(rom_addr), 3);
        step(1);
        chk("lit_rr_second", 32'(rom_addr), 0);
        step(6);
        // Pointer wrap: pointer at 3, only req0/req2 valid.
        vld = 4'b0101; set_addr(0, 11'h100); set_addr(2, 11'h222);
        step(1);
        chk("lit_wrap0", 32'(rom_addr), 32'h100);
        step(1);
        chk("lit_wrap2", 32'(rom_addr), 32'h222);
        step(1);
        chk("lit_wrap0b", 32'(rom_addr), 32'h100);
        vld = '0;
        // Timeout collision: request arrives in the cycle the idle count hits 4.
        step(6);
        vld = 4'b0010; set_addr(1, 11'h033);
        step(1);
        chk("lit_coll_state", 32'(state), 2);
        chk("lit_coll_pw", 32'(rom_pwreninb), 0);
        chk("lit_coll_addr", 32'(rom_addr), 32'h033);
        vld = '0;
        step(2);
        chk("lit_coll_rsp", 32'(rsp_vld), 32'b0010);
        // Reset mid-read, just after edge T+1.
        vld = 4'b1000; set_addr(3, 11'h044);
        step(1);
        vld = '0;
        step(1);
        rst = 1'b1;
        #1;
        chk("lit_rst_pw", 32'(rom_pwreninb), 1);
        chk("lit_rst_state", 32'(state), 0);
        chk("lit_rst_ren", 32'(rom_ren), 0);
        chk("lit_rst_addr", 32'(rom_addr), 0);
        step(2);
        chk("lit_rst_norsp", 32'(rsp_vld), 0);
        rst = 1'b0;
        step(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
